// File: rtl/add_unit_sched_if.sv
// add_unit_sched_if
//   Bundles the request, adder and CDB signals of the add/sub issue scheduler.
//   master : scheduler side (add_unit_sched)
//   slave  : environment side (reservation stations, adder, CDB)
//   Signals:
//     rs_req/rs_a/rs_b/rs_sub/rs_tag  per-entry requests and operands
//     rs_gnt                          one-hot combinational grant
//     alu_a/alu_b/alu_sub, alu_res    adder operands/op and its result
//     cdb_valid/cdb_ready/cdb_data/cdb_tag  result broadcast handshake
//     busy                            any stage occupied
`timescale 1ns/1ps
interface add_unit_sched_if #(
   parameter int unsigned N     = 4,
   parameter int unsigned TAG_W = 3
);
   logic [N-1:0]       rs_req;
   logic [N*32-1:0]    rs_a;
   logic [N*32-1:0]    rs_b;
   logic [N-1:0]       rs_sub;
   logic [N*TAG_W-1:0] rs_tag;
   logic [N-1:0]       rs_gnt;
   logic [31:0]        alu_a;
   logic [31:0]        alu_b;
   logic               alu_sub;
   logic [31:0]        alu_res;
   logic               cdb_valid;
   logic               cdb_ready;
   logic [31:0]        cdb_data;
   logic [TAG_W-1:0]   cdb_tag;
   logic               busy;

   modport master (
      input  rs_req, rs_a, rs_b, rs_sub, rs_tag, alu_res, cdb_ready,
      output rs_gnt, alu_a, alu_b, alu_sub, cdb_valid, cdb_data, cdb_tag, busy
   );

   modport slave (
      output rs_req, rs_a, rs_b, rs_sub, rs_tag, alu_res, cdb_ready,
      input  rs_gnt, alu_a, alu_b, alu_sub, cdb_valid, cdb_data, cdb_tag, busy
   );
endinterface

// File: rtl/add_unit_sched.sv
// add_unit_sched
//   Issue scheduler for the shared 32-bit add/sub unit. Round-robin picks one
//   ready reservation-station entry, the E stage drives the adder, the W stage
//   broadcasts the result and tag on the CDB with valid/ready. Both stages
//   stall under CDB back-pressure; flush kills everything in flight.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     flush  synchronous kill of in-flight ops
//     bus    add_unit_sched_if.master (requests, adder, CDB, busy)
//   Optional: define ADD_UNIT_SCHED_PERF_EN to add perf_issue (grant count)
//   and perf_stall (cdb_valid & !cdb_ready cycle count) outputs.
`timescale 1ns/1ps
module add_unit_sched #(
   parameter int unsigned N     = 4,
   parameter int unsigned TAG_W = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   add_unit_sched_if.master       bus
`ifdef ADD_UNIT_SCHED_PERF_EN
   ,
   output logic [31:0]            perf_issue,
   output logic [31:0]            perf_stall
`endif
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic             e_valid_q, e_valid_d;
   logic [31:0]      e_a_q, e_a_d;
   logic [31:0]      e_b_q, e_b_d;
   logic             e_sub_q, e_sub_d;
   logic [TAG_W-1:0] e_tag_q, e_tag_d;
   logic             w_valid_q, w_valid_d;
   logic [31:0]      w_data_q, w_data_d;
   logic [TAG_W-1:0] w_tag_q, w_tag_d;
   logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

   logic             w_take, e_take, grant_en;
   logic [N-1:0]     pick;
   logic [PW-1:0]    next_ptr;
   logic [PW-1:0]    idx;
   logic             found;
   logic [31:0]      sel_a, sel_b;
   logic             sel_sub;
   logic [TAG_W-1:0] sel_tag;

   assign w_take   = !w_valid_q || bus.cdb_ready;
   assign e_take   = !e_valid_q || w_take;
   // rst_n gating keeps the combinational grant quiet while reset is held
   assign grant_en = rst_n && e_take && !flush && (|bus.rs_req);

   // Round-robin search starting at rr_ptr
   always_comb begin
      pick     = '0;
      next_ptr = rr_ptr_q;
      found    = 1'b0;
      idx      = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = PW'((32'(rr_ptr_q) + k) % N);
         if (!found && bus.rs_req[idx]) begin
            pick[idx] = 1'b1;
            next_ptr  = PW'((32'(idx) + 1) % N);
            found     = 1'b1;
         end
      end
   end

   // One-hot OR-mux of the winning entry's operands
   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_sub = 1'b0;
      sel_tag = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (pick[i]) begin
            sel_a   = sel_a   | bus.rs_a[i*32 +: 32];
            sel_b   = sel_b   | bus.rs_b[i*32 +: 32];
            sel_sub = sel_sub | bus.rs_sub[i];
            sel_tag = sel_tag | bus.rs_tag[i*TAG_W +: TAG_W];
         end
      end
   end

   assign bus.rs_gnt = grant_en ? pick : '0;

   always_comb begin
      e_valid_d = e_valid_q;
      e_a_d     = e_a_q;
      e_b_d     = e_b_q;
      e_sub_d   = e_sub_q;
      e_tag_d   = e_tag_q;
      w_valid_d = w_valid_q;
      w_data_d  = w_data_q;
      w_tag_d   = w_tag_q;
      rr_ptr_d  = rr_ptr_q;

      if (w_take) begin
         w_valid_d = e_valid_q;
         w_data_d  = bus.alu_res;
         w_tag_d   = e_tag_q;
      end
      if (e_take) begin
         e_valid_d = grant_en;
         if (grant_en) begin
            e_a_d    = sel_a;
            e_b_d    = sel_b;
            e_sub_d  = sel_sub;
            e_tag_d  = sel_tag;
            rr_ptr_d = next_ptr;
         end
      end
      if (flush) begin
         e_valid_d = 1'b0;
         w_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_valid_q <= 1'b0;
         e_a_q     <= '0;
         e_b_q     <= '0;
         e_sub_q   <= 1'b0;
         e_tag_q   <= '0;
         w_valid_q <= 1'b0;
         w_data_q  <= '0;
         w_tag_q   <= '0;
         rr_ptr_q  <= '0;
      end else begin
         e_valid_q <= e_valid_d;
         e_a_q     <= e_a_d;
         e_b_q     <= e_b_d;
         e_sub_q   <= e_sub_d;
         e_tag_q   <= e_tag_d;
         w_valid_q <= w_valid_d;
         w_data_q  <= w_data_d;
         w_tag_q   <= w_tag_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   assign bus.alu_a     = e_a_q;
   assign bus.alu_b     = e_b_q;
   assign bus.alu_sub   = e_sub_q;
   assign bus.cdb_valid = w_valid_q;
   assign bus.cdb_data  = w_data_q;
   assign bus.cdb_tag   = w_tag_q;
   assign bus.busy      = e_valid_q || w_valid_q;

`ifdef ADD_UNIT_SCHED_PERF_EN
   logic [31:0] perf_issue_q, perf_stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issue_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_issue_q <= perf_issue_q + 32'(grant_en);
         perf_stall_q <= perf_stall_q + 32'(w_valid_q && !bus.cdb_ready);
      end
   end

   assign perf_issue = perf_issue_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_add_unit_sched.sv
`timescale 1ns/1ps
module tb_add_unit_sched;
   localparam int unsigned N     = 4;
   localparam int unsigned TAG_W = 3;

   logic clk;
   logic rst_n;
   logic flush;

   add_unit_sched_if #(.N(N), .TAG_W(TAG_W)) bus ();

`ifdef ADD_UNIT_SCHED_PERF_EN
   logic [31:0] perf_issue, perf_stall;
`endif

   add_unit_sched #(.N(N), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .bus        (bus.master)
`ifdef ADD_UNIT_SCHED_PERF_EN
      ,
      .perf_issue (perf_issue),
      .perf_stall (perf_stall)
`endif
   );

   // Behavioural adder
   assign bus.alu_res = bus.alu_sub ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: ordered list of in-flight ops; the oldest may sit on the CDB
   typedef struct {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
      bit               on_cdb;
   } op_t;
   op_t q[$];
   int  rr = 0;
   logic [N-1:0] last_gnt = '0;

   logic [31:0]      a_v [N];
   logic [31:0]      b_v [N];
   logic [TAG_W-1:0] t_v [N];

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      rr = 0;
      last_gnt = '0;
   endtask

   // Drive one cycle at the negedge, check outputs, then apply the clock edge to the model
   task automatic step(input logic [N-1:0] req, input logic [N-1:0] sub,
                       input logic ready, input logic fl);
      bit           head_on_cdb, e_busy, w_take, e_take;
      int           win;
      logic [N-1:0] exp_gnt;
      op_t          tmp;
      bus.rs_req    = req;
      bus.rs_sub    = sub;
      bus.cdb_ready = ready;
      flush         = fl;
      for (int i = 0; i < N; i++) begin
         bus.rs_a[i*32 +: 32]       = a_v[i];
         bus.rs_b[i*32 +: 32]       = b_v[i];
         bus.rs_tag[i*TAG_W +: TAG_W] = t_v[i];
      end
      #1;
      head_on_cdb = (q.size() > 0) && q[0].on_cdb;
      e_busy      = (q.size() > 0) && (q.size() - int'(head_on_cdb) > 0);
      w_take      = !head_on_cdb || ready;
      e_take      = !e_busy || w_take;
      exp_gnt     = '0;
      win         = -1;
      if (e_take && !fl && req != '0) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (rr + k) % N;
            if (win < 0 && req[j]) win = j;
         end
         exp_gnt[win] = 1'b1;
      end
      chk("rs_gnt",    32'(bus.rs_gnt),    32'(exp_gnt));
      chk("cdb_valid", 32'(bus.cdb_valid), 32'(head_on_cdb));
      chk("busy",      32'(bus.busy),      32'(q.size() > 0));
      if (head_on_cdb) begin
         chk("cdb_data", bus.cdb_data,      q[0].res);
         chk("cdb_tag",  32'(bus.cdb_tag),  32'(q[0].tag));
      end
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         if (head_on_cdb && ready) void'(q.pop_front());
         if (q.size() > 0 && !q[0].on_cdb) begin
            tmp = q[0];
            tmp.on_cdb = 1'b1;
            q[0] = tmp;
         end
         if (win >= 0) begin
            tmp.res    = sub[win] ? (a_v[win] - b_v[win]) : (a_v[win] + b_v[win]);
            tmp.tag    = t_v[win];
            tmp.on_cdb = 1'b0;
            q.push_back(tmp);
            rr = (win + 1) % N;
         end
      end
      last_gnt = exp_gnt;
      @(negedge clk);
   endtask

   task automatic rand_operands();
      for (int i = 0; i < N; i++) begin
         a_v[i] = $urandom;
         b_v[i] = $urandom;
         t_v[i] = TAG_W'($urandom);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.rs_req    = '1;
      bus.rs_a      = '0;
      bus.rs_b      = '0;
      bus.rs_sub    = '0;
      bus.rs_tag    = '0;
      bus.cdb_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         a_v[i] = '0; b_v[i] = '0; t_v[i] = TAG_W'(i);
      end
      @(negedge clk);
      @(negedge clk);
      // Reset state with requests pending: no grant, everything zero
      chk("rst_gnt",   32'(bus.rs_gnt),    32'd0);
      chk("rst_valid", 32'(bus.cdb_valid), 32'd0);
      chk("rst_busy",  32'(bus.busy),      32'd0);
      chk("rst_alu_a", bus.alu_a,          32'd0);
      chk("rst_data",  bus.cdb_data,       32'd0);
      chk("rst_tag",   32'(bus.cdb_tag),   32'd0);
      rst_n = 1'b1;
      model_reset();

      // Single op 5+3, tag 2
      a_v[0] = 32'd5; b_v[0] = 32'd3; t_v[0] = 3'd2;
      step(4'b0001, 4'b0000, 1'b1, 1'b0);
      repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b0);

      // Subtract wrap 0-1
      a_v[0] = 32'd0; b_v[0] = 32'd1;
      step(4'b0001, 4'b0001, 1'b1, 1'b0);
      repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b0);

      // Round-robin with all entries requesting
      for (int i = 0; i < N; i++) begin
         a_v[i] = 32'(100 * (i + 1)); b_v[i] = 32'(i); t_v[i] = TAG_W'(i);
      end
      repeat (4) step(4'b1111, 4'b0000, 1'b1, 1'b0);
      repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b0);

      // Back-pressure mid-stream
      rand_operands();
      repeat (2) step(4'b1111, 4'b0101, 1'b1, 1'b0);
      repeat (3) step(4'b1111, 4'b0101, 1'b0, 1'b0);
      repeat (2) step(4'b1111, 4'b0101, 1'b1, 1'b0);
      repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b0);

      // Flush with both stages full and the CDB stalled
      rand_operands();
      repeat (2) step(4'b1111, 4'b0000, 1'b0, 1'b0);
      step(4'b1111, 4'b0000, 1'b0, 1'b1);
      step(4'b0000, 4'b0000, 1'b1, 1'b0);
      step(4'b1111, 4'b0000, 1'b1, 1'b0);
      repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b0);

      // Asynchronous reset between edges with both stages busy
      rand_operands();
      repeat (2) step(4'b1111, 4'b0000, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.cdb_valid), 32'd0);
      chk("arst_busy",  32'(bus.busy),      32'd0);
      chk("arst_gnt",   32'(bus.rs_gnt),    32'd0);
      chk("arst_data",  bus.cdb_data,       32'd0);
      chk("arst_alu_b", bus.alu_b,          32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (2) step(4'b0000, 4'b0000, 1'b1, 1'b0);
      step(4'b1111, 4'b0000, 1'b1, 1'b0);
      repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b0);

      // Random traffic; a granted entry drops its request next cycle
      for (int n = 0; n < 400; n++) begin
         logic [N-1:0] req;
         rand_operands();
         req = N'($urandom) & ~last_gnt;
         step(req, N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
      end
      repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
